// File: rtl/ecc_enc_sequencer.sv
// APB-slave sequencer for the codeword encoder: holds DATA/WIDTH/RESULT/STATUS registers,
// launches one registered encoder pass per start command and captures the encoded word.
module ecc_enc_sequencer #(
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32,
   parameter int DATA_WIDTH      = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   output logic [AMBA_WORD-1:0]       PRDATA,
   output logic [AMBA_WORD-1:0]       enc_data,
   output logic                       enc_small,
   output logic                       enc_medium,
   output logic                       enc_large,
   input  logic [AMBA_WORD-1:0]       enc_result,
   output logic                       busy,
   output logic                       operation_done
);

   localparam logic [4:0] ADDR_CTRL   = 5'h00;
   localparam logic [4:0] ADDR_DATA   = 5'h04;
   localparam logic [4:0] ADDR_WIDTH  = 5'h08;
   localparam logic [4:0] ADDR_RESULT = 5'h0C;
   localparam logic [4:0] ADDR_STATUS = 5'h10;
   localparam logic [1:0] WIDTH_BAD   = 2'b11;

   typedef enum logic [1:0] {IDLE, LAUNCH, CAPTURE, DONE} state_e;

   state_e                 stateQ, stateD;
   logic [DATA_WIDTH-1:0]  dataQ, dataD;
   logic [DATA_WIDTH-1:0]  dataShQ, dataShD;
   logic [1:0]             widthQ, widthD;
   logic [1:0]             widthShQ, widthShD;
   logic [AMBA_WORD-1:0]   resultQ, resultD;
   logic                   doneQ, doneD;
   logic                   errQ, errD;
   logic                   ovrQ, ovrD;

   logic [4:0] addr;
   logic       wrEn;
   logic       startReq;
   logic       canStart;
   logic       startAcc;
   logic       startValid;
   logic       unusedAddrBits;

   assign addr           = PADDR[4:0];
   assign unusedAddrBits = ^PADDR[AMBA_ADDR_WIDTH-1:5];
   assign wrEn           = PSEL & PENABLE & PWRITE;
   assign startReq       = wrEn && (addr == ADDR_CTRL) && PWDATA[0];
   // A start is only taken when no operation is in flight; DONE allows back-to-back launch.
   assign canStart       = (stateQ == IDLE) || (stateQ == DONE);
   assign startAcc       = startReq && canStart;
   assign startValid     = startAcc && (widthQ != WIDTH_BAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (startAcc) stateD = startValid ? LAUNCH : DONE;
         LAUNCH:  stateD = CAPTURE;
         CAPTURE: stateD = DONE;
         DONE:    if (startAcc) stateD = startValid ? LAUNCH : DONE;
                  else          stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      busy           = 1'b0;
      operation_done = 1'b0;
      enc_small      = 1'b0;
      enc_medium     = 1'b0;
      enc_large      = 1'b0;
      case (stateQ)
         LAUNCH, CAPTURE: begin
            busy       = 1'b1;
            enc_small  = (widthShQ == 2'b00);
            enc_medium = (widthShQ == 2'b01);
            enc_large  = (widthShQ == 2'b10);
         end
         DONE:    operation_done = 1'b1;
         default: ;
      endcase
   end

   assign enc_data = AMBA_WORD'(dataShQ);

   // Register next-state: APB writes first, then sequencer events so hardware sets win over W1C.
   always_comb begin
      dataD    = dataQ;
      widthD   = widthQ;
      dataShD  = dataShQ;
      widthShD = widthShQ;
      resultD  = resultQ;
      doneD    = doneQ;
      errD     = errQ;
      ovrD     = ovrQ;
      if (wrEn) begin
         case (addr)
            ADDR_DATA:   dataD  = DATA_WIDTH'(PWDATA);
            ADDR_WIDTH:  widthD = PWDATA[1:0];
            ADDR_STATUS: begin
               if (PWDATA[1]) doneD = 1'b0;
               if (PWDATA[2]) errD  = 1'b0;
               if (PWDATA[3]) ovrD  = 1'b0;
            end
            default: ;
         endcase
      end
      if (startAcc) begin
         dataShD  = dataQ;
         widthShD = widthQ;
         if (startValid) begin
            doneD = 1'b0;
            errD  = 1'b0;
         end else begin
            errD  = 1'b1;
         end
      end
      if (startReq && !canStart) ovrD = 1'b1;
      if (stateQ == CAPTURE) resultD = enc_result;
      if (stateD == DONE) doneD = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dataQ    <= '0;
         widthQ   <= '0;
         dataShQ  <= '0;
         widthShQ <= '0;
         resultQ  <= '0;
         doneQ    <= 1'b0;
         errQ     <= 1'b0;
         ovrQ     <= 1'b0;
      end else begin
         dataQ    <= dataD;
         widthQ   <= widthD;
         dataShQ  <= dataShD;
         widthShQ <= widthShD;
         resultQ  <= resultD;
         doneQ    <= doneD;
         errQ     <= errD;
         ovrQ     <= ovrD;
      end
   end

   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (addr)
            ADDR_DATA:   PRDATA = AMBA_WORD'(dataQ);
            ADDR_WIDTH:  PRDATA = {{(AMBA_WORD-2){1'b0}}, widthQ};
            ADDR_RESULT: PRDATA = resultQ;
            ADDR_STATUS: PRDATA = {{(AMBA_WORD-4){1'b0}}, ovrQ, errQ, doneQ, busy};
            default:     PRDATA = '0;
         endcase
      end
   end

endmodule
